// File: rtl/thumb_code_align_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : thumb_code_align_buffer_if
// Description : Fetch-side and decode-side handshake bundle of the Thumb
//               instruction alignment buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface thumb_code_align_buffer_if #(
  parameter int FETCH_HW = 2,
  parameter int DEPTH_HW = 8
);
  localparam int OFF_W = ($clog2(FETCH_HW) > 1) ? $clog2(FETCH_HW) : 1;
  localparam int CNT_W = $clog2(DEPTH_HW + 1);

  logic                    flush;
  logic [OFF_W-1:0]        flush_off;
  logic                    fetch_valid;
  logic                    fetch_ready;
  logic [16*FETCH_HW-1:0]  fetch_data;
  logic                    inst_valid;
  logic                    inst_ready;
  logic [31:0]             inst_code;
  logic                    inst_is32;
  logic [CNT_W-1:0]        hw_count;

  modport master (
    output flush, flush_off, fetch_valid, fetch_data, inst_ready,
    input  fetch_ready, inst_valid, inst_code, inst_is32, hw_count
  );

  modport slave (
    input  flush, flush_off, fetch_valid, fetch_data, inst_ready,
    output fetch_ready, inst_valid, inst_code, inst_is32, hw_count
  );
endinterface
`default_nettype wire

// File: rtl/thumb_code_align_buffer.sv
`default_nettype none
// ============================================================================
// Module      : thumb_code_align_buffer
// Description : Circular halfword queue that realigns fetch words into whole
//               16/32-bit Thumb instructions for the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module thumb_code_align_buffer #(
  parameter int FETCH_HW  = 2,
  parameter int DEPTH_HW  = 8,
  parameter bit THUMB2_EN = 1'b1
) (
  input  wire logic                clk,
  input  wire logic                rst,
  thumb_code_align_buffer_if.slave ab_io
);
  localparam int OFF_W = ($clog2(FETCH_HW) > 1) ? $clog2(FETCH_HW) : 1;
  localparam int CNT_W = $clog2(DEPTH_HW + 1);
  localparam int PTR_W = $clog2(DEPTH_HW);

  localparam logic [CNT_W-1:0] C_FETCH     = CNT_W'(FETCH_HW);
  localparam logic [CNT_W-1:0] C_READY_MAX = CNT_W'(DEPTH_HW - FETCH_HW);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO       = CNT_W'(2);

  if ((FETCH_HW != 2) && (FETCH_HW != 4)) begin : g_bad_fetch_hw
    $error("FETCH_HW must be 2 or 4");
  end
  if ((DEPTH_HW < 2 * FETCH_HW) || ((DEPTH_HW & (DEPTH_HW - 1)) != 0)) begin : g_bad_depth_hw
    $error("DEPTH_HW must be a power of two and at least 2*FETCH_HW");
  end

  logic [15:0]      mem_q [DEPTH_HW];
  logic [15:0]      mem_d [DEPTH_HW];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OFF_W-1:0] off_q, off_d;

  logic [PTR_W-1:0] rd_ptr_p1;
  logic [15:0]      hw0, hw1;
  logic             head32;
  logic             valid;
  logic             ready;
  logic             push, pop;
  logic [CNT_W-1:0] push_n, pop_n;

  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
  assign hw0       = mem_q[rd_ptr_q];
  assign hw1       = mem_q[rd_ptr_p1];

  assign head32 = THUMB2_EN && ((hw0[15:11] == 5'b11101) ||
                                (hw0[15:11] == 5'b11110) ||
                                (hw0[15:11] == 5'b11111));

  // A lone leading half of a 32-bit instruction is held back until its tail lands.
  assign valid = head32 ? (cnt_q >= C_TWO) : (cnt_q >= C_ONE);
  assign ready = (cnt_q <= C_READY_MAX);

  assign push   = ab_io.fetch_valid && ready && !ab_io.flush;
  assign pop    = valid && ab_io.inst_ready && !ab_io.flush;
  assign push_n = C_FETCH - CNT_W'(off_q);
  assign pop_n  = head32 ? C_TWO : C_ONE;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      for (int i = 0; i < FETCH_HW; i++) begin
        if (i >= int'(off_q)) begin
          mem_d[wr_ptr_q + PTR_W'(i) - PTR_W'(off_q)] = ab_io.fetch_data[16*i +: 16];
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    if (ab_io.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      off_d    = ab_io.flush_off;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
        off_d    = '0;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
      end
      cnt_d = cnt_q + (push ? push_n : '0) - (pop ? pop_n : '0);
    end
  end

  // Storage carries no reset; the count alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      off_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
    end
  end

  assign ab_io.fetch_ready = ready;
  assign ab_io.inst_valid  = valid;
  assign ab_io.inst_is32   = valid && head32;
  assign ab_io.inst_code   = !valid ? 32'h0 : (head32 ? {hw0, hw1} : {16'h0000, hw0});
  assign ab_io.hw_count    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_thumb_code_align_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_thumb_code_align_buffer
// Description : Scoreboard bench: halfword-stream reference model plus
//               directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thumb_code_align_buffer;
  localparam int FETCH_HW = 2;
  localparam int DEPTH_HW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  thumb_code_align_buffer_if #(.FETCH_HW(FETCH_HW), .DEPTH_HW(DEPTH_HW)) bus ();

  thumb_code_align_buffer #(
    .FETCH_HW (FETCH_HW),
    .DEPTH_HW (DEPTH_HW),
    .THUMB2_EN(1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ab_io(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: raw halfwords not yet forming a whole instruction, and the
  // queue of complete expected instructions as {is32, code}.
  logic [15:0] pend [$];
  logic [32:0] expq [$];
  int          m_off  = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit starts32(input logic [15:0] h);
    return (h[15:11] == 5'b11101) || (h[15:11] == 5'b11110) || (h[15:11] == 5'b11111);
  endfunction

  function automatic int model_cnt();
    int n = pend.size();
    foreach (expq[k]) n += expq[k][32] ? 2 : 1;
    return n;
  endfunction

  task automatic parse();
    while (pend.size() > 0) begin
      if (starts32(pend[0])) begin
        if (pend.size() < 2) break;
        expq.push_back({1'b1, pend[0], pend[1]});
        void'(pend.pop_front());
        void'(pend.pop_front());
      end else begin
        expq.push_back({1'b0, 16'h0000, pend[0]});
        void'(pend.pop_front());
      end
    end
  endtask

  // Monitor + model: compare what the DUT presents, then apply this cycle's
  // handshakes to the reference before the clock edge commits them.
  always @(negedge clk) begin
    bit          m_valid;
    bit          m_ready;
    logic [32:0] head;
    if (rst) begin
      pend.delete();
      expq.delete();
      m_off  = 0;
      mon_en = 1'b1;
    end else begin
      m_valid = expq.size() > 0;
      m_ready = (DEPTH_HW - model_cnt()) >= FETCH_HW;
      head    = m_valid ? expq[0] : 33'h0;
      if (mon_en) begin
        chk("inst_valid",  32'(bus.inst_valid),  32'(m_valid));
        chk("inst_code",   bus.inst_code,        head[31:0]);
        chk("inst_is32",   32'(bus.inst_is32),   32'(head[32]));
        chk("hw_count",    32'(bus.hw_count),    32'(model_cnt()));
        chk("fetch_ready", 32'(bus.fetch_ready), 32'(m_ready));
      end
      if (bus.flush) begin
        pend.delete();
        expq.delete();
        m_off = int'(bus.flush_off);
      end else begin
        if (m_valid && bus.inst_ready) void'(expq.pop_front());
        if (bus.fetch_valid && m_ready) begin
          for (int i = m_off; i < FETCH_HW; i++) pend.push_back(bus.fetch_data[16*i +: 16]);
          m_off = 0;
          parse();
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.inst_ready  = 1'b0;
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    case ($urandom_range(0, 4))
      0: h[15:11] = 5'b11101;
      1: h[15:11] = 5'b11110;
      2: h[15:11] = 5'b11111;
      default: ;
    endcase
    return h;
  endfunction

  initial begin
    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.flush_off   = '0;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = '0;
    bus.inst_ready  = 1'b0;

    // Reset
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_inst_valid",  32'(bus.inst_valid),  32'd0);
    chk("rst_inst_code",   bus.inst_code,        32'd0);
    chk("rst_hw_count",    32'(bus.hw_count),    32'd0);
    chk("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);

    // Two 16-bit instructions from one word
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'hBF00_4770; bus.inst_ready = 1'b1;
    cyc();
    bus.fetch_valid = 1'b0;
    chk("s2_first_code", bus.inst_code, 32'h0000_4770);
    chk("s2_first_is32", 32'(bus.inst_is32), 32'd0);
    cyc();
    chk("s2_second_code", bus.inst_code, 32'h0000_BF00);
    cyc();
    chk("s2_empty_valid", 32'(bus.inst_valid), 32'd0);

    // Flush with start offset 1
    quiet();
    bus.flush = 1'b1; bus.flush_off = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("s3_cnt0", 32'(bus.hw_count), 32'd0);
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'h2001_4770; bus.inst_ready = 1'b1;
    cyc();
    bus.fetch_valid = 1'b0;
    chk("s3_cnt1", 32'(bus.hw_count), 32'd1);
    chk("s3_code", bus.inst_code, 32'h0000_2001);
    cyc();
    chk("s3_cnt_end", 32'(bus.hw_count), 32'd0);

    // 32-bit instruction spanning two fetch words
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'hF000_4770; bus.inst_ready = 1'b1;
    cyc();
    bus.fetch_valid = 1'b0;
    chk("s4_first_code", bus.inst_code, 32'h0000_4770);
    cyc();
    chk("s4_wait_valid", 32'(bus.inst_valid), 32'd0);
    chk("s4_wait_cnt",   32'(bus.hw_count),   32'd1);
    cyc();
    chk("s4_wait2_valid", 32'(bus.inst_valid), 32'd0);
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'hBF00_F800;
    cyc();
    bus.fetch_valid = 1'b0;
    chk("s4_span_code", bus.inst_code, 32'hF000_F800);
    chk("s4_span_is32", 32'(bus.inst_is32), 32'd1);
    cyc();
    chk("s4_tail_code", bus.inst_code, 32'h0000_BF00);
    cyc();
    chk("s4_end_valid", 32'(bus.inst_valid), 32'd0);

    // Full and backpressure
    quiet();
    bus.fetch_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.fetch_data = {16'(16'h2101 + 2 * k), 16'(16'h2100 + 2 * k)};
      cyc();
    end
    chk("s5_full_cnt",   32'(bus.hw_count),    32'd8);
    chk("s5_full_ready", 32'(bus.fetch_ready), 32'd0);
    bus.fetch_data = 32'h2201_2200;
    cyc();
    chk("s5_held_cnt", 32'(bus.hw_count), 32'd8);
    bus.inst_ready = 1'b1;
    cyc();
    chk("s5_pop1_cnt",   32'(bus.hw_count),    32'd7);
    chk("s5_pop1_ready", 32'(bus.fetch_ready), 32'd0);
    cyc();
    bus.fetch_valid = 1'b0;
    chk("s5_pop2_cnt",   32'(bus.hw_count),    32'd6);
    chk("s5_pop2_ready", 32'(bus.fetch_ready), 32'd1);
    for (int k = 0; k < 8; k++) cyc();
    chk("s5_drained", 32'(bus.hw_count), 32'd0);

    // Flush colliding with push and pop
    quiet();
    bus.flush = 1'b1; bus.flush_off = 1'b1;
    cyc();
    bus.flush = 1'b0;
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'h2302_2301;
    cyc();
    bus.fetch_data = 32'h2304_2303;
    cyc();
    chk("s6_pre_cnt", 32'(bus.hw_count), 32'd3);
    bus.flush = 1'b1; bus.flush_off = 1'b0; bus.fetch_data = 32'h2399_2398; bus.inst_ready = 1'b1;
    cyc();
    bus.flush = 1'b0; bus.fetch_valid = 1'b0;
    chk("s6_cnt0",   32'(bus.hw_count),   32'd0);
    chk("s6_valid0", 32'(bus.inst_valid), 32'd0);
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'h2402_2401;
    cyc();
    bus.fetch_valid = 1'b0;
    chk("s6_next_code", bus.inst_code, 32'h0000_2401);
    cyc();
    chk("s6_next2_code", bus.inst_code, 32'h0000_2402);
    cyc();

    // Randomized traffic, occasional flush and mid-run reset
    for (int c = 0; c < 4000; c++) begin
      rst             = ($urandom_range(0, 599) == 0);
      bus.flush       = ($urandom_range(0, 39) == 0);
      bus.flush_off   = 1'($urandom_range(0, 1));
      bus.fetch_valid = ($urandom_range(0, 2) != 0);
      bus.fetch_data  = {rand_hw(), rand_hw()};
      bus.inst_ready  = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 3) == 0);
      cyc();
    end
    rst = 1'b0;
    quiet();
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 12; k++) cyc();
    quiet();
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
